// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus IF/ID pipeline register.
// Keeps the PC, issues one outstanding request at a time to instruction
// memory (req/ready, then rvalid), and presents {pc, instruction, valid}
// to decode. Handles decode stall, flush and taken-branch redirect.
// Optional build macro: FETCH_MISALIGN_CHECK_EN. When defined, a redirect
// to a non-word-aligned target raises a sticky fetch_misalign flag and
// parks fetch until reset. When undefined, the low two target bits are
// ignored and fetch_misalign is tied low.
module fetch_stage #(
    parameter int                     PC_WIDTH    = 64,
    parameter int                     INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC    = '0,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR   = 32'h00000013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   flush,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ready,
    input  logic                   imem_rvalid,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic [INSTR_WIDTH-1:0] instruction_out,
    output logic                   valid_out,
    output logic                   fetch_misalign
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic [PC_WIDTH-1:0]     pc;
    logic [PC_WIDTH-1:0]     pc_nx;
    logic [PC_WIDTH-1:0]     pc_inc;
    logic [PC_WIDTH-1:0]     redirect_tgt;

    // Skid holds a response that arrived while decode was stalled.
    logic                    skid_vld;
    logic [INSTR_WIDTH-1:0]  skid_instr;
    logic                    skid_load;
    logic                    skid_clr;

    // A fetch completes this cycle; fetch_instr is what lands in IF/ID.
    logic                    fetch_done;
    logic [INSTR_WIDTH-1:0]  fetch_instr;

    // Forces IF/ID to bubbles while fetch is parked on a misaligned target.
    logic                    park;

    assign imem_addr = pc;
    // Sequential PC advance wraps silently modulo 2^PC_WIDTH.
    assign pc_inc    = pc + PC_WIDTH'(4);

`ifdef FETCH_MISALIGN_CHECK_EN
    logic misalign_q;
    logic mis_set;

    assign redirect_tgt   = redirect_pc;
    assign park           = misalign_q | mis_set;
    assign fetch_misalign = misalign_q;
`else
    logic unused_low_bits;

    // Targets are word aligned by construction: drop the low two bits.
    assign redirect_tgt    = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    assign unused_low_bits = ^redirect_pc[1:0];
    assign park            = 1'b0;
    assign fetch_misalign  = 1'b0;
`endif

    // Next-state / next-PC decode; redirect overrides the normal flow.
    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        fetch_done  = 1'b0;
        fetch_instr = imem_rdata;
        skid_load   = 1'b0;
        skid_clr    = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        mis_set     = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (!park) state_nx = S_REQ;
            end
            S_REQ: begin
                if (imem_ready) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    if (stall) begin
                        skid_load = 1'b1;
                        state_nx  = S_HOLD;
                    end else begin
                        fetch_done = 1'b1;
                        pc_nx      = pc_inc;
                        state_nx   = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                // pc still addresses the skidded instruction here.
                if (!stall) begin
                    fetch_done  = skid_vld;
                    fetch_instr = skid_instr;
                    skid_clr    = 1'b1;
                    pc_nx       = pc_inc;
                    state_nx    = S_REQ;
                end
            end
            S_DROP: begin
                if (imem_rvalid) state_nx = S_REQ;
            end
            default: state_nx = S_IDLE;
        endcase

        if (redirect_valid && state != S_IDLE) begin
            fetch_done = 1'b0;
            skid_load  = 1'b0;
            skid_clr   = 1'b1;
            pc_nx      = redirect_tgt;
            case (state)
                // A request accepted this very cycle still owes a response.
                S_REQ:   state_nx = imem_ready  ? S_DROP : S_REQ;
                S_WAIT:  state_nx = imem_rvalid ? S_REQ  : S_DROP;
                // Still waiting on the abandoned response: keep discarding.
                S_DROP:  state_nx = imem_rvalid ? S_REQ  : S_DROP;
                default: state_nx = S_REQ;
            endcase
`ifdef FETCH_MISALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) begin
                mis_set  = 1'b1;
                state_nx = S_IDLE;
            end
`endif
        end
    end

    // FSM state, PC, registered request strobe and skid buffer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            skid_vld   <= 1'b0;
            skid_instr <= NOP_INSTR;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            imem_req <= (state_nx == S_REQ);
            if (skid_load) begin
                skid_vld   <= 1'b1;
                skid_instr <= imem_rdata;
            end else if (skid_clr) begin
                skid_vld <= 1'b0;
            end
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Sticky misaligned-redirect flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst)         misalign_q <= 1'b0;
        else if (mis_set) misalign_q <= 1'b1;
    end
`endif

    // IF/ID register: flush beats stall, stall beats new fetch, else bubble.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_out          <= '0;
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
        end else if (flush || park) begin
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
        end else if (stall) begin
            valid_out <= valid_out;
        end else if (fetch_done) begin
            pc_out          <= pc;
            instruction_out <= fetch_instr;
            valid_out       <= 1'b1;
        end else begin
            instruction_out <= NOP_INSTR;
            valid_out       <= 1'b0;
        end
    end

endmodule
